tone_tuner: RTL

- Upstream control stage for the triangle/delta-sigma tone path; replaces the fixed phase increment in the top level.
- Debounces the two board buttons and steps the phase increment (tuning word) up or down by one octave per press, saturating at the configured limits.
- Accumulates the phase word every clock and drives it to the triangle generator.
- Exports limit flags for the LEDs.

---
 rtl/tone_pkg.sv | 28 ++
 rtl/tone_tuner_if.sv | 27 ++
 rtl/button_debounce.sv | 52 +++++
 rtl/tone_tuner.sv | 80 ++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared constants and helpers for the tone tuner control path.
package tone_pkg;

  localparam int unsigned CLK_FREQUENCY   = 12_000_000;
  localparam int unsigned PHASE_BITS      = 20;
  localparam int unsigned DPHASE_INIT     = 87;
  localparam int unsigned DPHASE_MIN      = 1;
  localparam int unsigned DPHASE_MAX      = 262144;
  localparam int unsigned DEBOUNCE_CYCLES = CLK_FREQUENCY / 100;

  typedef enum logic [1:0] {
    StepNone = 2'd0,
    StepDown = 2'd1,
    StepUp   = 2'd2
  } step_e;

  // Simultaneous up and down presses cancel out.
  function automatic step_e step_dir(input logic up, input logic down);
    step_e dir;
    case ({up, down})
      2'b10:   dir = StepUp;
      2'b01:   dir = StepDown;
      default: dir = StepNone;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/tone_tuner_if.sv
// Button inputs and tone outputs of the tuner.
interface tone_tuner_if #(
  parameter int unsigned PHASE_BITS = tone_pkg::PHASE_BITS
);
  logic [1:0]            btn;
  logic [PHASE_BITS-1:0] phase;
  logic [PHASE_BITS-1:0] dphase;
  logic                  at_max;
  logic                  at_min;

  // master: the tuner; slave: the board / triangle generator side.
  modport master (
    input  btn,
    output phase,
    output dphase,
    output at_max,
    output at_min
  );

  modport slave (
    output btn,
    input  phase,
    input  dphase,
    input  at_max,
    input  at_min
  );
endinterface

// File: rtl/button_debounce.sv
// Two-flop synchroniser, stability counter and registered press pulse for one button.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic            stable_dly_q;
  logic            press_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised level disagrees with the accepted one.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= btn;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      press_q      <= stable_q & ~stable_dly_q;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/tone_tuner.sv
// Octave-stepping tuning word with saturation, plus the phase accumulator it drives.
module tone_tuner
  import tone_pkg::*;
#(
  parameter int unsigned PHASE_BITS      = tone_pkg::PHASE_BITS,
  parameter int unsigned DPHASE_INIT     = tone_pkg::DPHASE_INIT,
  parameter int unsigned DPHASE_MIN      = tone_pkg::DPHASE_MIN,
  parameter int unsigned DPHASE_MAX      = tone_pkg::DPHASE_MAX,
  parameter int unsigned DEBOUNCE_CYCLES = tone_pkg::DEBOUNCE_CYCLES
) (
  input  logic  clk,
  input  logic  rst,
  tone_tuner_if.master bus
);

  logic                  up_press, down_press;
  logic [PHASE_BITS-1:0] dphase_q, dphase_d;
  logic [PHASE_BITS-1:0] phase_q;
  logic [PHASE_BITS:0]   dbl;
  logic [PHASE_BITS-1:0] half;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce_up (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn[1]),
    .press (up_press)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce_down (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn[0]),
    .press (down_press)
  );

  // One extra bit so the doubling can never wrap before the limit check.
  assign dbl  = {dphase_q, 1'b0};
  assign half = dphase_q >> 1;

  always_comb begin
    dphase_d = dphase_q;
    case (step_dir(up_press, down_press))
      StepUp: begin
        if (dbl > (PHASE_BITS + 1)'(DPHASE_MAX)) begin
          dphase_d = PHASE_BITS'(DPHASE_MAX);
        end else begin
          dphase_d = dbl[PHASE_BITS-1:0];
        end
      end
      StepDown: begin
        if (half < PHASE_BITS'(DPHASE_MIN)) begin
          dphase_d = PHASE_BITS'(DPHASE_MIN);
        end else begin
          dphase_d = half;
        end
      end
      default: dphase_d = dphase_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dphase_q <= PHASE_BITS'(DPHASE_INIT);
      phase_q  <= '0;
    end else begin
      dphase_q <= dphase_d;
      phase_q  <= phase_q + dphase_q;
    end
  end

  assign bus.phase  = phase_q;
  assign bus.dphase = dphase_q;
  assign bus.at_max = (dphase_q == PHASE_BITS'(DPHASE_MAX));
  assign bus.at_min = (dphase_q == PHASE_BITS'(DPHASE_MIN));

endmodule
